mips_cpu_avalon_ram: RTL

Avalon-MM memory responder that services the multicycle MIPS CPU's instruction and data bus: read, write, byteenable, waitrequest. It holds a word-organised RAM behind a single address window and inserts a programmable number of wait states. It sits between the CPU bus and the testbench/top level and is the block the controller's fetch and load/store states handshake with.

---
 rtl/mips_cpu_avalon_ram_if.sv | 29 ++
 rtl/mips_cpu_avalon_ram.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mips_cpu_avalon_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_avalon_ram_if
// Description : Avalon-MM bus between the multicycle MIPS CPU (master) and
//               the RAM responder (slave).
//               address/read/write/byteenable/writedata : master -> slave
//               waitrequest/readdata                    : slave  -> master
// Revision    : 1.0  initial release
// ============================================================================
interface mips_cpu_avalon_ram_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_avalon_ram.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_avalon_ram
// Description : Avalon-MM word RAM responder for the multicycle MIPS CPU with
//               a fixed number of programmable wait states.
// Ports       : clk          - rising-edge clock
//               reset_n      - synchronous reset, active low
//               bus          - Avalon-MM slave (address, read, write,
//                              byteenable, writedata, waitrequest, readdata)
//               stall_inject - holds the current transfer in WAIT while high
//               err          - sticky protocol / range error flag
//               xfer_count   - completed transfers since reset (wraps)
// Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_avalon_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    mips_cpu_avalon_ram_if.slave       bus,
    input  wire logic                  stall_inject,
    output logic                       err,
    output logic [31:0]                xfer_count
);

    localparam int c_aw = $clog2(DEPTH_WORDS);
    // The request cycle seen in IDLE already counts as one wait cycle, so the
    // counter is loaded one short to give WAIT_CYCLES+1 high cycles in total.
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [29:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_is_wr;
    logic [31:0] r_rdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic            w_req;
    logic            w_direct;
    logic            w_wait_done;
    logic            w_access;
    logic [29:0]     w_a_addr;
    logic [3:0]      w_a_be;
    logic [31:0]     w_a_wdata;
    logic            w_a_is_wr;
    logic [29:0]     w_off;
    logic            w_in_range;
    logic [c_aw-1:0] w_idx;

    assign w_req = bus.read | bus.write;

    // With zero wait states the access happens on the accepting edge itself;
    // a stall in that cycle parks the transfer in WAIT instead.
    assign w_direct    = (r_state == IDLE) && w_req && (WAIT_CYCLES == 0) && !stall_inject;
    assign w_wait_done = (r_state == WAIT) && !stall_inject && (r_cnt == 4'd0);
    assign w_access    = w_direct | w_wait_done;

    // Access fields come straight from the bus on the direct path, otherwise
    // from the values latched when the request was accepted.
    assign w_a_addr  = (r_state == IDLE) ? bus.address[31:2] : r_addr;
    assign w_a_be    = (r_state == IDLE) ? bus.byteenable    : r_be;
    assign w_a_wdata = (r_state == IDLE) ? bus.writedata     : r_wdata;
    assign w_a_is_wr = (r_state == IDLE) ? bus.write         : r_is_wr;

    // Word-granular compare; the lower bound is checked separately so a
    // below-window address cannot wrap into range.
    assign w_off      = w_a_addr - BASE_ADDR[31:2];
    assign w_in_range = (w_a_addr >= BASE_ADDR[31:2]) && ((w_off >> c_aw) == '0);
    assign w_idx      = w_off[c_aw-1:0];

    assign bus.waitrequest = w_req && (r_state != RESPOND);
    assign bus.readdata    = r_rdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_rdata    <= 32'd0;
            err        <= 1'b0;
            xfer_count <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= bus.address[31:2];
                        r_be    <= bus.byteenable;
                        r_wdata <= bus.writedata;
                        r_is_wr <= bus.write;
                        r_cnt   <= c_wait_load;
                        if (bus.read && bus.write) begin
                            err <= 1'b1;
                        end
                        r_state <= w_direct ? RESPOND : WAIT;
                    end
                end
                WAIT: begin
                    // Master dropped the request before acceptance: finish the
                    // transfer anyway but flag the violation.
                    if (!w_req) begin
                        err <= 1'b1;
                    end
                    if (!stall_inject) begin
                        if (r_cnt == 4'd0) begin
                            r_state <= RESPOND;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                RESPOND: begin
                    xfer_count <= xfer_count + 32'd1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_access) begin
                if (!w_in_range) begin
                    err <= 1'b1;
                end
                if (!w_a_is_wr) begin
                    r_rdata <= w_in_range ? mem[w_idx] : 32'd0;
                end
            end
        end
    end

    // RAM contents survive reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (reset_n && w_access && w_a_is_wr && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (w_a_be[i]) begin
                    mem[w_idx][8*i +: 8] <= w_a_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
